// File: rtl/ipv4_frame_tx.sv
// IPv4-over-Ethernet frame transmitter: latches addresses and payload, computes
// the IPv4 header checksum over ten cycles, then streams the frame byte-serially.
module ipv4_frame_tx #(
  parameter int          PAYLOAD_BYTES   = 2,
  parameter int          MIN_FRAME_BYTES = 60,
  parameter logic [7:0]  TTL             = 8'h80,
  parameter logic [7:0]  PROTOCOL        = 8'h04
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [31:0]                ACCELERATOR_IP_ADDRESS,
  input  logic [47:0]                ACCELERATOR_MAC_ADDRESS,
  input  logic [31:0]                RECIPIENT_IP_ADDRESS,
  input  logic [47:0]                RECIPIENT_MAC_ADDRESS,
  input  logic [8*PAYLOAD_BYTES-1:0] RECIPIENT_PAYLOAD,
  input  logic                       START_IP_TXN,
  output logic                       READY_FOR_SEND,
  output logic [7:0]                 MAC_DATA_OUT,
  output logic                       MAC_DATA_VALID,
  input  logic                       MAC_DATA_READY,
  output logic                       MAC_DATA_LAST,
  output logic                       MAC_DATA_TUSER
);

  localparam int PW         = 8 * PAYLOAD_BYTES;
  localparam int HDR_BYTES  = 34;
  localparam int FRAME_RAW  = HDR_BYTES + PAYLOAD_BYTES;
  localparam int FRAME_N    = (FRAME_RAW > MIN_FRAME_BYTES) ? FRAME_RAW : MIN_FRAME_BYTES;
  localparam logic [10:0] LAST_IDX = 11'(FRAME_N - 1);
  localparam logic [15:0] TOT_LEN  = 16'(20 + PAYLOAD_BYTES);

  // state | meaning
  // IDLE  | waiting for START_IP_TXN, READY_FOR_SEND high
  // CSUM  | one header word per cycle into the 20-bit accumulator
  // FOLD  | fold carries, invert, store checksum
  // SEND  | stream bytes 0..N-1 over valid/ready
  typedef enum logic [1:0] {S_IDLE, S_CSUM, S_FOLD, S_SEND} state_t;

  state_t       state_q, state_d;
  logic [47:0]  dmac_q, dmac_d, smac_q, smac_d;
  logic [31:0]  sip_q, sip_d, dip_q, dip_d;
  logic [PW-1:0] pay_q, pay_d;
  logic [15:0]  id_q, id_d, id_cnt_q, id_cnt_d;
  logic [3:0]   word_q, word_d;
  logic [19:0]  acc_q, acc_d;
  logic [15:0]  csum_q, csum_d;
  logic [10:0]  idx_q, idx_d;
  logic [7:0]   data_q, data_d;
  logic         valid_q, valid_d, last_q, last_d, rdy_q, rdy_d;

  logic [271:0] hdr_v;
  logic [7:0]   hdr_b [64];
  logic [10:0]  nidx;
  logic         is_pay;
  logic [7:0]   byte_n;
  logic [15:0]  word_v;
  logic [16:0]  fold1;
  logic [15:0]  fold2;

  always_comb begin
    hdr_v = {dmac_q, smac_q, 16'h0800, 8'h45, 8'h00, TOT_LEN, id_q, 16'h0000,
             TTL, PROTOCOL, csum_q, sip_q, dip_q};
    for (int i = 0; i < 64; i++) hdr_b[i] = 8'h00;
    for (int i = 0; i < HDR_BYTES; i++) hdr_b[i] = hdr_v[(HDR_BYTES-1-i)*8 +: 8];
  end

  // Index of the byte to be loaded into the output register next.
  assign nidx   = valid_q ? (idx_q + 11'd1) : idx_q;
  assign is_pay = (nidx >= 11'(HDR_BYTES)) && (nidx < 11'(FRAME_RAW));
  assign byte_n = (nidx < 11'(HDR_BYTES)) ? hdr_b[nidx[5:0]] :
                  is_pay ? pay_q[PW-1 -: 8] : 8'h00;

  always_comb begin
    case (word_q)
      4'd0:    word_v = 16'h4500;
      4'd1:    word_v = TOT_LEN;
      4'd2:    word_v = id_q;
      4'd4:    word_v = {TTL, PROTOCOL};
      4'd6:    word_v = sip_q[31:16];
      4'd7:    word_v = sip_q[15:0];
      4'd8:    word_v = dip_q[31:16];
      4'd9:    word_v = dip_q[15:0];
      default: word_v = 16'h0000;
    endcase
  end

  assign fold1 = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

  always_comb begin
    state_d  = state_q;
    dmac_d   = dmac_q;
    smac_d   = smac_q;
    sip_d    = sip_q;
    dip_d    = dip_q;
    pay_d    = pay_q;
    id_d     = id_q;
    id_cnt_d = id_cnt_q;
    word_d   = word_q;
    acc_d    = acc_q;
    csum_d   = csum_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    rdy_d    = rdy_q;
    case (state_q)
      S_IDLE: begin
        if (START_IP_TXN) begin
          dmac_d  = RECIPIENT_MAC_ADDRESS;
          smac_d  = ACCELERATOR_MAC_ADDRESS;
          sip_d   = ACCELERATOR_IP_ADDRESS;
          dip_d   = RECIPIENT_IP_ADDRESS;
          pay_d   = RECIPIENT_PAYLOAD;
          id_d    = id_cnt_q;
          word_d  = 4'd0;
          acc_d   = 20'd0;
          rdy_d   = 1'b0;
          state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        acc_d  = acc_q + {4'd0, word_v};
        word_d = word_q + 4'd1;
        if (word_q == 4'd9) state_d = S_FOLD;
      end
      S_FOLD: begin
        csum_d  = ~fold2;
        idx_d   = 11'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        // First SEND cycle only primes the output register with byte 0.
        if (!valid_q || (MAC_DATA_READY && !last_q)) begin
          data_d  = byte_n;
          valid_d = 1'b1;
          last_d  = (nidx == LAST_IDX);
          idx_d   = nidx;
          if (is_pay) pay_d = pay_q << 8;
        end else if (MAC_DATA_READY) begin
          data_d   = 8'h00;
          valid_d  = 1'b0;
          last_d   = 1'b0;
          rdy_d    = 1'b1;
          id_cnt_d = id_cnt_q + 16'd1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= S_IDLE;
      dmac_q   <= '0;
      smac_q   <= '0;
      sip_q    <= '0;
      dip_q    <= '0;
      pay_q    <= '0;
      id_q     <= '0;
      id_cnt_q <= '0;
      word_q   <= '0;
      acc_q    <= '0;
      csum_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      dmac_q   <= dmac_d;
      smac_q   <= smac_d;
      sip_q    <= sip_d;
      dip_q    <= dip_d;
      pay_q    <= pay_d;
      id_q     <= id_d;
      id_cnt_q <= id_cnt_d;
      word_q   <= word_d;
      acc_q    <= acc_d;
      csum_q   <= csum_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      rdy_q    <= rdy_d;
    end
  end

  assign READY_FOR_SEND = rdy_q;
  assign MAC_DATA_OUT   = data_q;
  assign MAC_DATA_VALID = valid_q;
  assign MAC_DATA_LAST  = last_q;
  assign MAC_DATA_TUSER = 1'b0;

endmodule

// File: tb/tb_ipv4_frame_tx.sv
// Directed bench for ipv4_frame_tx: default-width instance plus a 40-byte payload instance.
module tb_ipv4_frame_tx;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [31:0]  a_ip, r_ip;
  logic [47:0]  a_mac, r_mac;
  logic [15:0]  pay2;
  logic [319:0] pay40;
  logic         start0 = 1'b0, start40 = 1'b0, rdy0 = 1'b1, rdy40 = 1'b1;
  logic         rfs0, v0, l0, u0, rfs40, v40, l40, u40;
  logic [7:0]   d0, d40;

  always #5 ACLK = ~ACLK;

  ipv4_frame_tx dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .ACCELERATOR_IP_ADDRESS(a_ip), .ACCELERATOR_MAC_ADDRESS(a_mac),
    .RECIPIENT_IP_ADDRESS(r_ip), .RECIPIENT_MAC_ADDRESS(r_mac),
    .RECIPIENT_PAYLOAD(pay2), .START_IP_TXN(start0), .READY_FOR_SEND(rfs0),
    .MAC_DATA_OUT(d0), .MAC_DATA_VALID(v0), .MAC_DATA_READY(rdy0),
    .MAC_DATA_LAST(l0), .MAC_DATA_TUSER(u0)
  );

  ipv4_frame_tx #(.PAYLOAD_BYTES(40)) dut40 (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .ACCELERATOR_IP_ADDRESS(a_ip), .ACCELERATOR_MAC_ADDRESS(a_mac),
    .RECIPIENT_IP_ADDRESS(r_ip), .RECIPIENT_MAC_ADDRESS(r_mac),
    .RECIPIENT_PAYLOAD(pay40), .START_IP_TXN(start40), .READY_FOR_SEND(rfs40),
    .MAC_DATA_OUT(d40), .MAC_DATA_VALID(v40), .MAC_DATA_READY(rdy40),
    .MAC_DATA_LAST(l40), .MAC_DATA_TUSER(u40)
  );

  int          n_chk = 0, n_pass = 0;
  logic [7:0]  rx_q [$];
  int          last_pos, lasts, first_k;
  bit          bubble, tmo;
  logic [7:0]  exp_b [128];
  int          exp_n;
  logic [287:0] s1_hdr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int stall_len(input int idx);
    case (idx)
      4: return 1;  5: return 2;  6: return 3;
      7: return 4;  20: return 5; 33: return 6;
      default: return 0;
    endcase
  endfunction

  task automatic launch(input bit use40);
    if (use40) start40 = 1'b1; else start0 = 1'b1;
    @(negedge ACLK);
    chk(use40 ? "rfs_fall40" : "rfs_fall", use40 ? rfs40 : rfs0, 1'b0);
    start0 = 1'b0;
    start40 = 1'b0;
  endtask

  // Collects one frame; optional stalls, a START pulse at pulse_idx and a reset at abort_idx.
  task automatic capture(input bit use40, input bit stall_en, input int pulse_idx,
                         input int abort_idx, input int n);
    int idx, stall_rem, stalled_idx;
    bit seen_v, prev_stall, r;
    logic [9:0] prev;
    logic v, l;
    logic [7:0] d;
    rx_q.delete();
    last_pos = -1; lasts = 0; first_k = -1; bubble = 0; tmo = 1;
    idx = 0; stall_rem = 0; stalled_idx = -1; seen_v = 0; prev_stall = 0; prev = '0;
    for (int k = 2; k < 3000; k++) begin
      @(negedge ACLK);
      v = use40 ? v40 : v0;
      l = use40 ? l40 : l0;
      d = use40 ? d40 : d0;
      if (prev_stall) chk($sformatf("stall_hold_b%0d", idx), {d, v, l}, prev);
      if (!use40) start0 = (pulse_idx >= 0) && v && (idx == pulse_idx);
      if (v && !seen_v) begin first_k = k; seen_v = 1; end
      if (seen_v && !v) bubble = 1;
      if (v && idx == abort_idx) begin
        ARESETN = 1'b0;
        #1;
        chk("abort_rfs", rfs0, 1'b1);
        chk("abort_valid", v0, 1'b0);
        chk("abort_last", l0, 1'b0);
        chk("abort_data", d0, 8'h00);
        tmo = 0;
        return;
      end
      r = 1'b1;
      if (stall_en && v && idx != stalled_idx && stall_len(idx) > 0) begin
        stall_rem = stall_len(idx);
        stalled_idx = idx;
      end
      if (stall_rem > 0) begin r = 1'b0; stall_rem--; end
      if (use40) rdy40 = r; else rdy0 = r;
      prev_stall = v && !r;
      prev = {d, v, l};
      if (v && r) begin
        rx_q.push_back(d);
        if (l) begin lasts++; last_pos = idx; end
        idx++;
        if (idx == n) begin tmo = 0; break; end
      end
    end
  endtask

  task automatic build_exp(input logic [47:0] dm, input logic [47:0] sm, input logic [31:0] si,
                           input logic [31:0] di, input logic [15:0] id, input logic [15:0] cs,
                           input int pb, input logic [319:0] pl);
    logic [271:0] h;
    h = {dm, sm, 16'h0800, 8'h45, 8'h00, 16'(20 + pb), id, 16'h0000, 8'h80, 8'h04, cs, si, di};
    exp_n = (34 + pb > 60) ? 34 + pb : 60;
    for (int i = 0; i < 128; i++) exp_b[i] = 8'h00;
    for (int i = 0; i < 34; i++) exp_b[i] = h[(33 - i) * 8 +: 8];
    for (int j = 0; j < pb; j++) exp_b[34 + j] = pl[(pb - 1 - j) * 8 +: 8];
  endtask

  task automatic load_s1;
    for (int i = 0; i < 128; i++) exp_b[i] = 8'h00;
    for (int i = 0; i < 36; i++) exp_b[i] = s1_hdr[(35 - i) * 8 +: 8];
    exp_n = 60;
  endtask

  task automatic compare_frame(input string tag, input bit skip_cs);
    chk({tag, "_len"}, rx_q.size(), exp_n);
    for (int i = 0; i < exp_n; i++)
      if (!(skip_cs && (i == 24 || i == 25)))
        chk($sformatf("%s_b%0d", tag, i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_b[i]);
    chk({tag, "_lastpos"}, last_pos, exp_n - 1);
    chk({tag, "_lastcnt"}, lasts, 1);
    chk({tag, "_bubble"}, bubble, 1'b0);
    chk({tag, "_timeout"}, tmo, 1'b0);
    chk({tag, "_latency"}, first_k, 13);
  endtask

  task automatic post_frame(input bit use40);
    @(negedge ACLK);
    chk("post_rfs", use40 ? rfs40 : rfs0, 1'b1);
    chk("post_valid", use40 ? v40 : v0, 1'b0);
    chk("post_last", use40 ? l40 : l0, 1'b0);
  endtask

  initial begin
    int s;
    bit any_v;
    logic [31:0] k_aip, k_rip;
    logic [47:0] k_amac, k_rmac;
    s1_hdr = 288'h32dabbadebd5_54b00bedabba_0800_4500_0016_0000_0000_8004_1f68_beefbeef_deadbeef_01ff;
    a_mac = 48'h54b00bedabba; a_ip = 32'hbeefbeef;
    r_mac = 48'h32dabbadebd5; r_ip = 32'hdeadbeef;
    pay2  = 16'h01ff;
    for (int i = 0; i < 40; i++) pay40[(39 - i) * 8 +: 8] = 8'(i);

    repeat (3) @(negedge ACLK);
    chk("rst_rfs", rfs0, 1'b1);
    chk("rst_valid", v0, 1'b0);
    chk("rst_last", l0, 1'b0);
    chk("rst_data", d0, 8'h00);
    chk("rst_tuser", u0, 1'b0);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    // Frame 1 then back-to-back frame 2 started on the first legal edge.
    launch(0);
    capture(0, 0, -1, -1, 60);
    load_s1();
    compare_frame("f1", 0);
    post_frame(0);
    launch(0);
    capture(0, 0, -1, -1, 60);
    build_exp(r_mac, a_mac, a_ip, r_ip, 16'h0001, 16'h1f67, 2, {304'd0, pay2});
    compare_frame("f2", 0);
    post_frame(0);
    repeat (3) @(negedge ACLK);

    // START during SEND ignored, then reset at byte 30.
    launch(0);
    capture(0, 0, 10, 30, 60);
    chk("abort_reached", tmo, 1'b0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    any_v = 0;
    repeat (15) begin
      @(negedge ACLK);
      if (v0 || !rfs0) any_v = 1;
    end
    chk("no_queued_start", any_v, 1'b0);

    // Stalled frame after reset: identification restarts at 0.
    launch(0);
    capture(0, 1, -1, -1, 60);
    load_s1();
    compare_frame("f3", 0);
    post_frame(0);
    rdy0 = 1'b1;

    launch(1);
    capture(1, 0, -1, -1, 74);
    build_exp(r_mac, a_mac, a_ip, r_ip, 16'h0000, 16'h1f42, 40, pay40);
    compare_frame("f40", 0);
    post_frame(1);

    // Random addresses, scrambled after START; header must sum to FFFF.
    for (int r = 0; r < 2; r++) begin
      repeat (2) @(negedge ACLK);
      a_ip = $urandom(); r_ip = $urandom();
      a_mac = {16'($urandom()), $urandom()}; r_mac = {16'($urandom()), $urandom()};
      k_aip = a_ip; k_rip = r_ip; k_amac = a_mac; k_rmac = r_mac;
      launch(0);
      a_ip = $urandom(); r_ip = $urandom();
      a_mac = {16'($urandom()), $urandom()}; r_mac = {16'($urandom()), $urandom()};
      capture(0, 0, -1, -1, 60);
      build_exp(k_rmac, k_amac, k_aip, k_rip, 16'(r + 1), 16'h0000, 2, {304'd0, pay2});
      compare_frame($sformatf("rnd%0d", r), 1);
      s = 0;
      if (rx_q.size() >= 34)
        for (int w = 0; w < 10; w++) s += {rx_q[14 + 2 * w], rx_q[15 + 2 * w]};
      s = (s & 32'hffff) + (s >>> 16);
      s = (s & 32'hffff) + (s >>> 16);
      chk($sformatf("rnd%0d_hdrsum", r), s, 32'hffff);
      post_frame(0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
